// File: rtl/bit_unstuffer_param.sv
// -----------------------------------------------------------------------------
// bit_unstuffer_param
//
// USB receive-path bit unstuffer. It sits between the line decoder and the
// byte assembler. After RUN_LEN consecutive ones, the next bit is a stuffed
// bit. That bit is removed from the stream. If it does not carry STUFF_VAL,
// stuff_err is flagged. The input and output use valid/ready handshakes, with
// a one-entry output register. A per-packet synchronous clear restarts the
// run tracking.
//
// Optional build macro: UNSTUFF_NRZI_EN
//   When this macro is defined, an NRZI decoder sits in front of the
//   unstuffer. A decoded bit is 1 when the line level is unchanged.
//
// Parameters:
//   RUN_LEN    ones that force a stuffed bit (2..15)
//   STUFF_VAL  required value of the stuffed bit
//   CNT_W      run counter width (derived; do not override)
//
// Ports:
//   clk        system clock, rising edge
//   RST        synchronous active-high reset
//   clear      synchronous packet-boundary clear pulse
//   in_bit     stuffed (optionally NRZI) input bit
//   in_valid   in_bit valid
//   in_ready   block accepts in_bit this cycle
//   out_bit    unstuffed data bit
//   out_valid  out_bit valid
//   out_ready  downstream accepts out_bit
//   stuff_err  one-cycle pulse on a bad stuffed bit
//
// State table:
//   ST_DATA | next accepted bit is a data bit
//   ST_DROP | next accepted bit is a stuffed bit and is consumed silently
// -----------------------------------------------------------------------------
module bit_unstuffer_param #(
  parameter int unsigned RUN_LEN   = 6,
  parameter logic        STUFF_VAL = 1'b0,
  parameter int unsigned CNT_W     = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic stuff_err
);

  if (RUN_LEN < 2 || RUN_LEN > 15) begin : g_bad_run_len
    $error("bit_unstuffer_param: RUN_LEN must be within 2..15");
  end

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             obit_d;
  logic             ovld_d;
  logic             err_d;
  logic             accept;
  logic             d;

  // in_ready has no path from in_valid. It only looks at clear and at the
  // state of the output register.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef UNSTUFF_NRZI_EN
  logic prev_level;

  // An unchanged line level decodes as 1.
  assign d = (in_bit == prev_level);

  // Dropped stuffed bits still advance the line level.
  always_ff @(posedge clk) begin
    if (RST) begin
      prev_level <= 1'b1;
    end else if (clear) begin
      prev_level <= 1'b1;
    end else if (accept) begin
      prev_level <= in_bit;
    end
  end
`else
  assign d = in_bit;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = run_cnt;
    obit_d  = out_bit;
    ovld_d  = out_valid;
    err_d   = 1'b0;

    if (out_valid && out_ready) begin
      ovld_d = 1'b0;
    end

    if (clear) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      ovld_d  = 1'b0;
    end else if (accept) begin
      case (state_q)
        ST_DROP: begin
          // Accepting here means any held bit was already transferred, so
          // ovld_d is left as cleared above.
          state_d = ST_DATA;
          if (d == STUFF_VAL) begin
            cnt_d = '0;
          end else begin
            err_d = 1'b1;
            // A bad stuffed 1 counts as the first one of a new run.
            cnt_d = {{(CNT_W-1){1'b0}}, d};
          end
        end
        default: begin
          obit_d = d;
          ovld_d = 1'b1;
          if (!d) begin
            cnt_d = '0;
          end else if (run_cnt == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DROP;
          end else begin
            cnt_d = run_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= ST_DATA;
      run_cnt   <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt   <= cnt_d;
      out_bit   <= obit_d;
      out_valid <= ovld_d;
      stuff_err <= err_d;
    end
  end

endmodule

// File: doc/bit_unstuffer_param.md
Name: bit_unstuffer_param

Overview:
Parametrised next-generation bit unstuffer for the USB receive path. It sits between the line decoder and the byte assembler. It removes the stuffed bit inserted after RUN_LEN consecutive ones, flags stuffing violations, and supports valid/ready backpressure and a per-packet synchronous clear. NRZI decode can optionally be compiled in.

Parameters:
RUN_LEN, 6, number of consecutive ones that forces a stuffed bit; legal range 2..15.
STUFF_VAL, 1'b0, required value of the stuffed bit; any other value is a stuff error.
CNT_W, $clog2(RUN_LEN+1), width of the run counter; derived, not to be overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
clear  input  1  synchronous packet-boundary clear (SOP/EOP); single-cycle pulse.
in_bit  input  1  stuffed input bit (NRZI-encoded when UNSTUFF_NRZI_EN is defined).
in_valid  input  1  in_bit is valid this cycle.
in_ready  output  1  block accepts in_bit this cycle.
out_bit  output  1  unstuffed data bit.
out_valid  output  1  out_bit holds a valid bit.
out_ready  input  1  downstream accepts out_bit this cycle.
stuff_err  output  1  one-cycle pulse: stuffed-bit position carried a value other than STUFF_VAL.

Behaviour:
- Reset (RST=1 at clk edge): run_cnt=0, drop_pending=0, out_bit=0, out_valid=0, stuff_err=0; NRZI prev_level=1 when UNSTUFF_NRZI_EN is defined. RST has priority over everything else.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready); combinational, with no path from in_valid.
  - Input is accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - One-entry output register; out_bit is stable while out_valid && !out_ready.
- Latency: an accepted, non-dropped bit appears on out_bit/out_valid on the next cycle. Full throughput is one bit per cycle when out_ready is held high.
- Accepted bit d (d is the post-NRZI-decode value when UNSTUFF_NRZI_EN is defined):
  - drop_pending=1 (stuffed position): bit is consumed with no output.
    - out_valid <= 0 unless a held bit remains untransferred.
    - drop_pending <= 0.
    - If d==STUFF_VAL: run_cnt <= 0.
    - If d!=STUFF_VAL: stuff_err <= 1 for one cycle; run_cnt <= (d ? 1 : 0).
  - drop_pending=0: out_bit <= d, out_valid <= 1.
    - run_cnt <= d ? run_cnt+1 : 0.
    - If d==1 && run_cnt==RUN_LEN-1: drop_pending <= 1, run_cnt <= 0.
- run_cnt never exceeds RUN_LEN-1, so no wrap-around occurs.
- No accepted input, but out_valid && out_ready: out_valid <= 0.
- stuff_err defaults to 0 every cycle; it is asserted only in the cycle after the offending bit is accepted.
- clear=1 (RST=0):
  - run_cnt <= 0, drop_pending <= 0, out_valid <= 0, stuff_err <= 0; prev_level <= 1 when UNSTUFF_NRZI_EN is defined.
  - Any held output bit is discarded.
  - in_ready=0, so an input bit presented with clear is not consumed.
- Stall in the middle of a run: run_cnt and drop_pending hold. The stuffed bit is dropped on its next acceptance, regardless of how many cycles elapse.
- A run of ones spanning a stuffed 0 restarts counting from 0. A further RUN_LEN ones therefore schedule a new drop.
- Stuffed bit arriving while out_valid && !out_ready: in_ready=0, so the bit waits. Drop decisions occur only on acceptance.

Optional Feature:
Macro UNSTUFF_NRZI_EN.
- Defined: an internal NRZI decoder precedes unstuffing.
  - d = (in_bit == prev_level).
  - prev_level <= in_bit on every accepted bit, including dropped stuffed bits.
  - prev_level resets to 1 on RST and on clear.
- Not defined: d = in_bit; prev_level logic is absent. All other behaviour is identical.

Test Plan:
- RUN_LEN=6, out_ready=1, input 1,1,1,1,1,1,0,1,0 -> outputs 1,1,1,1,1,1,1,0 (stuffed 0 removed); stuff_err never set; in_ready constantly 1.
- RUN_LEN=6, input 1×7 -> six 1s output; 7th bit dropped; stuff_err pulses one cycle after the 7th acceptance; run_cnt=1 afterwards.
- Backpressure: out_ready=0 for 5 cycles after the first bit of 1,0,1 -> out_bit=1 held stable; in_ready=0; no bit lost; sequence 1,0,1 delivered once out_ready=1.
- clear asserted while drop_pending=1 and out_valid=1 -> next cycle out_valid=0; next bit 0 is output (not dropped); in_ready=0 during the clear cycle.
- RUN_LEN=3 instance: input 1,1,1,0,1,1,1,0 -> outputs 1,1,1,1,1,1; both stuffed 0s dropped.
- UNSTUFF_NRZI_EN defined, reset, then line levels 1,1,1,1,1,1,1,0 -> decoded 1×7 then 0: outputs 1×6; 7th decoded 1 dropped with stuff_err pulse; decoded 0 output.
